// File: rtl/service_4_alarm_set.sv
// Alarm-time entry stage feeding the Service 4 alarm checker.
// The user edits hours/minutes in BCD while set_en is high and commits with push_ok;
// the committed `alarm` word only ever changes on a commit or on reset.
// Optional build macro: ALARM_SET_REPEAT_EN adds auto-repeat on held up/down buttons.
module service_4_alarm_set #(
    parameter logic [15:0] DEFAULT_ALARM = 16'h0700,
    parameter int          BLINK_TICKS   = 8,
    parameter int          REPEAT_DELAY  = 16,
    parameter int          REPEAT_PERIOD = 4
) (
    input  logic        s2clk,
    input  logic        reset,
    input  logic        set_en,
    input  logic        push_u,
    input  logic        push_d,
    input  logic        push_sel,
    input  logic        push_ok,
    output logic [15:0] alarm,
    output logic        alarm_valid,
    output logic [15:0] edit_time,
    output logic [1:0]  edit_field,
    output logic        blink
);

    // State encoding doubles as the edit_field output.
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] EDIT_H = 2'b01;
    localparam logic [1:0] EDIT_M = 2'b10;

    localparam int              BW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0]   LAST = BW'(BLINK_TICKS - 1);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [15:0]   edit_nx;
    logic [15:0]   alarm_nx;
    logic          valid_nx;
    logic          step_up;
    logic          step_dn;
    logic [BW-1:0] blink_cnt;

    logic set_q, u_q, d_q, sel_q, ok_q;
    logic set_rise, u_rise, d_rise, sel_rise, ok_rise;
    logic rep_up, rep_dn;

    // BCD hour increment, 23 wraps to 00.
    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        if (h == 8'h23)           return 8'h00;
        else if (h[3:0] == 4'h9)  return {h[7:4] + 4'd1, 4'h0};
        else                      return {h[7:4], h[3:0] + 4'd1};
    endfunction

    // BCD hour decrement, 00 wraps to 23.
    function automatic logic [7:0] hour_dec(input logic [7:0] h);
        if (h == 8'h00)           return 8'h23;
        else if (h[3:0] == 4'h0)  return {h[7:4] - 4'd1, 4'h9};
        else                      return {h[7:4], h[3:0] - 4'd1};
    endfunction

    // BCD minute increment, 59 wraps to 00 with no carry into the hour.
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        if (m == 8'h59)           return 8'h00;
        else if (m[3:0] == 4'h9)  return {m[7:4] + 4'd1, 4'h0};
        else                      return {m[7:4], m[3:0] + 4'd1};
    endfunction

    // BCD minute decrement, 00 wraps to 59 with no borrow from the hour.
    function automatic logic [7:0] min_dec(input logic [7:0] m);
        if (m == 8'h00)           return 8'h59;
        else if (m[3:0] == 4'h0)  return {m[7:4] - 4'd1, 4'h9};
        else                      return {m[7:4], m[3:0] - 4'd1};
    endfunction

    assign set_rise = set_en   & ~set_q;
    assign u_rise   = push_u   & ~u_q;
    assign d_rise   = push_d   & ~d_q;
    assign sel_rise = push_sel & ~sel_q;
    assign ok_rise  = push_ok  & ~ok_q;

    assign edit_field = state;

`ifdef ALARM_SET_REPEAT_EN
    logic        hold_act;
    logic        hold_up;
    logic        rep_phase;
    logic [15:0] hold_cnt;
    logic [15:0] hold_inc;
    logic        hold_ok;
    logic        hold_start;
    logic        rep_hit;

    // A hold continues only while the same button stays pressed alone and nothing else happens.
    assign hold_ok = hold_act && set_en && (state != IDLE) && !ok_rise && !sel_rise &&
                     (hold_up ? (push_u && !push_d) : (push_d && !push_u));
    assign hold_start = (state != IDLE) && set_en && !ok_rise && !sel_rise &&
                        (u_rise ^ d_rise) && (u_rise ? !push_d : !push_u);
    assign hold_inc = hold_cnt + 16'd1;
    assign rep_hit  = hold_ok && (rep_phase ? (hold_inc == 16'(REPEAT_PERIOD))
                                            : (hold_inc == 16'(REPEAT_DELAY)));
    assign rep_up   = rep_hit &  hold_up;
    assign rep_dn   = rep_hit & ~hold_up;

    // Hold counter: first repeat after REPEAT_DELAY cycles, later ones every REPEAT_PERIOD.
    always_ff @(posedge s2clk or posedge reset) begin
        if (reset) begin
            hold_act  <= 1'b0;
            hold_up   <= 1'b0;
            rep_phase <= 1'b0;
            hold_cnt  <= 16'd0;
        end else if (hold_start) begin
            hold_act  <= 1'b1;
            hold_up   <= u_rise;
            rep_phase <= 1'b0;
            hold_cnt  <= 16'd0;
        end else if (hold_ok) begin
            if (rep_hit) begin
                rep_phase <= 1'b1;
                hold_cnt  <= 16'd0;
            end else begin
                hold_cnt  <= hold_inc;
            end
        end else begin
            hold_act  <= 1'b0;
            rep_phase <= 1'b0;
            hold_cnt  <= 16'd0;
        end
    end
`else
    logic [31:0] unused_repeat;
    assign unused_repeat = 32'(REPEAT_DELAY) ^ 32'(REPEAT_PERIOD);
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    // Next-state and datapath decision, one prioritised action per cycle.
    always_comb begin
        state_nx = state;
        edit_nx  = edit_time;
        alarm_nx = alarm;
        valid_nx = alarm_valid;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        case (state)
            IDLE: begin
                edit_nx = alarm;
                if (set_rise) state_nx = EDIT_H;
            end
            EDIT_H, EDIT_M: begin
                if (!set_en) begin
                    state_nx = IDLE;
                    edit_nx  = alarm;
                end else if (ok_rise) begin
                    alarm_nx = edit_time;
                    valid_nx = 1'b1;
                    state_nx = IDLE;
                end else if (sel_rise) begin
                    state_nx = (state == EDIT_H) ? EDIT_M : EDIT_H;
                end else if (u_rise | d_rise) begin
                    step_up = u_rise & ~d_rise;
                    step_dn = d_rise & ~u_rise;
                end else begin
                    step_up = rep_up;
                    step_dn = rep_dn;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (step_up) begin
            if (state == EDIT_H) edit_nx = {hour_inc(edit_time[15:8]), edit_time[7:0]};
            else                 edit_nx = {edit_time[15:8], min_inc(edit_time[7:0])};
        end else if (step_dn) begin
            if (state == EDIT_H) edit_nx = {hour_dec(edit_time[15:8]), edit_time[7:0]};
            else                 edit_nx = {edit_time[15:8], min_dec(edit_time[7:0])};
        end
    end

    // Edge-detect history, FSM state and committed/edited values.
    always_ff @(posedge s2clk or posedge reset) begin
        if (reset) begin
            set_q       <= 1'b0;
            u_q         <= 1'b0;
            d_q         <= 1'b0;
            sel_q       <= 1'b0;
            ok_q        <= 1'b0;
            state       <= IDLE;
            alarm       <= DEFAULT_ALARM;
            edit_time   <= DEFAULT_ALARM;
            alarm_valid <= 1'b0;
        end else begin
            set_q       <= set_en;
            u_q         <= push_u;
            d_q         <= push_d;
            sel_q       <= push_sel;
            ok_q        <= push_ok;
            state       <= state_nx;
            alarm       <= alarm_nx;
            edit_time   <= edit_nx;
            alarm_valid <= valid_nx;
        end
    end

    // Field blink: restarts from 0 on every state change, held low in IDLE.
    always_ff @(posedge s2clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if ((state_nx != state) || (state == IDLE)) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

endmodule

// File: doc/service_4_alarm_set.md
Name: service_4_alarm_set

Overview:
Alarm-time entry stage that sits directly upstream of the Service 4 alarm checker. It drives the 16-bit `alarm` word that the checker compares against `current`. The user enters edit mode with a switch, steps hours and minutes with push buttons, and commits with a confirm button. The block also drives a live edit value plus a field-blink flag for the 7-segment display path.

Parameters:
DEFAULT_ALARM, 16'h0700, alarm value after reset; must be legal BCD HH:MM in 24 h format.
BLINK_TICKS, 8, s2clk cycles per half-period of `blink`; must be ≥1.
REPEAT_DELAY, 16, hold cycles before the first auto-repeat step (used only with ALARM_SET_REPEAT_EN).
REPEAT_PERIOD, 4, cycles between later auto-repeat steps (used only with ALARM_SET_REPEAT_EN).

Ports:
s2clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
set_en  in  1  edit-enable switch (level)
push_u  in  1  increment button; debounced, synchronous to s2clk
push_d  in  1  decrement button; debounced, synchronous
push_sel  in  1  field-toggle button; debounced, synchronous
push_ok  in  1  commit button; debounced, synchronous
alarm  out  16  committed alarm {Ht,Ho,Mt,Mo}, BCD; feeds the checker's `alarm` input
alarm_valid  out  1  1 once any commit has occurred since reset
edit_time  out  16  value being edited; equals `alarm` in IDLE
edit_field  out  2  00 IDLE, 01 hour, 10 minute
blink  out  1  display blink for the active field; 0 in IDLE

Behaviour:
- Reset values:
  - alarm = DEFAULT_ALARM; edit_time = DEFAULT_ALARM
  - alarm_valid = 0; edit_field = 00; blink = 0
  - all edge-detect registers = 0; blink counter = 0
- Edge detection:
  - Each push_* and set_en has a registered copy of its previous value.
  - An edge is input = 1 while the registered copy = 0.
  - Action takes effect on the same clock edge at which the high level is first sampled, so outputs update one clock after the input rises.
  - A held button produces exactly one edge (without the repeat feature).
- FSM states are IDLE, EDIT_H, EDIT_M. `edit_field` encodes the state directly.
- IDLE:
  - edit_time tracks alarm.
  - A set_en rising edge → EDIT_H, with edit_time loaded from alarm.
  - set_en held high after a commit does not re-enter editing; a new rising edge is required.
  - Button edges are ignored.
- EDIT_H / EDIT_M, one action per cycle, priority order:
  1. set_en = 0 → IDLE; abort with alarm unchanged; edit_time reverts to alarm next cycle.
  2. ok edge → alarm <= edit_time as it stands before any same-cycle step; alarm_valid <= 1; → IDLE.
  3. sel edge → toggle EDIT_H ↔ EDIT_M; no value change.
  4. u edge and d edge in the same cycle → no change.
  5. u edge only → increment the active field.
  6. d edge only → decrement the active field.
- Hour arithmetic (BCD):
  - Increment: 23 → 00; x9 → (x+1)0, e.g. 09 → 10, 19 → 20.
  - Decrement: 00 → 23; x0 → (x−1)9.
- Minute arithmetic (BCD):
  - Increment: 59 → 00; decrement: 00 → 59.
  - No carry or borrow into the hour field.
- Nibbles are always legal BCD; no binary intermediate is ever exposed on outputs.
- blink:
  - In an edit state, a counter runs 0..BLINK_TICKS−1; blink toggles on wrap.
  - Counter and blink clear to 0 on every state change and in IDLE.
- alarm changes only on a commit or on reset. The downstream checker never sees a partial edit.
- Reset mid-edit: immediate return to reset values; edits are lost.

Optional Feature:
Macro: ALARM_SET_REPEAT_EN.
- Defined:
  - While push_u or push_d is held alone in an edit state, a hold counter starts at the edge.
  - An extra step occurs after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles.
  - The counter clears on release, on sel/ok edges, on state change, and when both buttons are held.
  - The same wrap rules apply to repeat steps.
- Undefined: no hold counter is built; exactly one step per edge; REPEAT_* parameters are ignored.

Test Plan:
1. Reset → alarm = 16'h0700, alarm_valid = 0, edit_field = 00. Then raise set_en → edit_field = 01, edit_time = 0700.
2. EDIT_H from 0700: 3 u edges → 1000; sel; 2 d edges → 1058; ok → alarm = 1058, alarm_valid = 1, edit_field = 00.
3. Wrap checks:
   - Hour 23 + u → 00; 00 + d → 23.
   - Minute 59 + u → 00 with the hour unchanged; 00 + d → 59.
4. Abort: edit to 1234, then drop set_en → alarm stays at the prior value, edit_time = alarm next cycle. Keeping set_en high after a commit does not re-enter edit.
5. Simultaneous edges:
   - u + d same cycle → no change.
   - ok + u same cycle at 0830 → alarm = 0830.
   - sel + u same cycle → field toggles, value unchanged.
   - Assert reset mid-edit → all reset values.
6. With ALARM_SET_REPEAT_EN and REPEAT_DELAY = 16, REPEAT_PERIOD = 4: hold u for 30 cycles in EDIT_M from 00 → 05 (1 edge step + steps at hold cycles 16, 20, 24, 28). Without the macro, the same stimulus → 01.
